// File: rtl/cpu_pkg.sv
// Shared definitions for the issue-stage register scoreboard.
package cpu_pkg;

    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;
    // HI/LO is tracked as one extra target just above the GPRs.
    localparam int HILO_IDX = NUM_REGS;
    localparam int CNT_W    = $clog2(NUM_REGS + 2);

    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [NUM_REGS:0] target_vec_t;

    // One-hot target vector for a GPR index plus optional HI/LO; r0 maps to nothing.
    function automatic target_vec_t target_vec(input reg_idx_t r, input logic hilo);
        target_vec_t v;
        v = '0;
        if (r != '0) v[r] = 1'b1;
        v[HILO_IDX] = hilo;
        return v;
    endfunction

endpackage

// File: rtl/cpu_scoreboard_if.sv
// Decoder-to-scoreboard issue handshake plus execution-unit writeback bus.
interface cpu_scoreboard_if #(
    parameter int NUM_WB = 2
);
    import cpu_pkg::*;

    logic                    issue_valid;
    logic                    issue_ready;
    reg_idx_t                issue_read_1;
    reg_idx_t                issue_read_2;
    reg_idx_t                issue_write;
    logic                    issue_nop;
    logic                    issue_hilo_read;
    logic                    issue_hilo_write;
    logic [NUM_WB-1:0]       wb_valid;
    logic [REG_W*NUM_WB-1:0] wb_reg;
    logic [NUM_WB-1:0]       wb_hilo;

    modport master (
        output issue_valid, issue_read_1, issue_read_2, issue_write,
               issue_nop, issue_hilo_read, issue_hilo_write,
               wb_valid, wb_reg, wb_hilo,
        input  issue_ready
    );

    modport slave (
        input  issue_valid, issue_read_1, issue_read_2, issue_write,
               issue_nop, issue_hilo_read, issue_hilo_write,
               wb_valid, wb_reg, wb_hilo,
        output issue_ready
    );

endinterface

// File: rtl/cpu_popcount33.sv
// Population count of a 33-bit target vector (31 GPRs, r0 slot, HI/LO).
module cpu_popcount33
    import cpu_pkg::*;
(
    input  target_vec_t      vec,
    output logic [CNT_W-1:0] count
);

    // Plain adder chain; synthesis folds it into a tree.
    always_comb begin
        count = '0;
        for (int i = 0; i <= NUM_REGS; i++) count = count + CNT_W'(vec[i]);
    end

endmodule

// File: rtl/cpu_scoreboard.sv
// Register-hazard scoreboard: blocks issue on RAW/WAW/full, releases on writeback.
module cpu_scoreboard
    import cpu_pkg::*;
#(
    parameter int NUM_WB          = 2,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    cpu_scoreboard_if.slave       sb,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic                  hilo_busy,
    output logic [CNT_W-1:0]      outstanding,
    output logic                  wb_error
);

    target_vec_t      busy_q, busy_nxt, set_vec, clr_vec, tgt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic             err_q, err_hit;
    logic             raw, waw, full, ready, fire;

    // Hazard checks look only at registered state: no same-cycle writeback bypass.
    always_comb begin
        raw   = busy_q[sb.issue_read_1] | busy_q[sb.issue_read_2]
              | (sb.issue_hilo_read & busy_q[HILO_IDX]);
        waw   = busy_q[sb.issue_write] | (sb.issue_hilo_write & busy_q[HILO_IDX]);
        full  = ((sb.issue_write != '0) | sb.issue_hilo_write)
              & (cnt_q == CNT_W'(MAX_OUTSTANDING));
        ready = !flush & (sb.issue_nop | !(raw | waw | full));
        fire  = sb.issue_valid & ready & !sb.issue_nop;
    end

    assign sb.issue_ready = ready;

    // Merge writeback releases; flag releases of idle targets and duplicate releases.
    always_comb begin
        clr_vec = '0;
        tgt     = '0;
        err_hit = 1'b0;
        for (int k = 0; k < NUM_WB; k++) begin
            tgt     = sb.wb_valid[k] ? target_vec(sb.wb_reg[k*REG_W +: REG_W], sb.wb_hilo[k])
                                     : '0;
            err_hit = err_hit | (|(tgt & ~busy_q)) | (|(tgt & clr_vec));
            clr_vec = clr_vec | tgt;
        end
        set_vec  = fire ? target_vec(sb.issue_write, sb.issue_hilo_write) : '0;
        // Set wins over clear; flush wins over everything.
        busy_nxt = flush ? '0 : ((busy_q & ~clr_vec) | set_vec);
    end

    // Outstanding is recomputed from the next state so it can never drift.
    cpu_popcount33 u_popcount (
        .vec   (busy_nxt),
        .count (cnt_nxt)
    );

    // State registers; wb_error is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_nxt;
            cnt_q  <= cnt_nxt;
            err_q  <= err_q | err_hit;
        end
    end

    assign busy_mask   = busy_q[NUM_REGS-1:0];
    assign hilo_busy   = busy_q[HILO_IDX];
    assign outstanding = cnt_q;
    assign wb_error    = err_q;

endmodule

// File: tb/tb_cpu_scoreboard.sv
// Scoreboard-style bench: driver pushes model expectations, monitor pops and compares.
module tb_cpu_scoreboard;
    import cpu_pkg::*;

    localparam int NWB  = 2;
    localparam int MAXO = 8;

    logic        clk, rst, flush;
    logic [31:0] busy_mask;
    logic        hilo_busy;
    logic [5:0]  outstanding;
    logic        wb_error;

    cpu_scoreboard_if #(.NUM_WB(NWB)) bus ();

    cpu_scoreboard #(.NUM_WB(NWB), .MAX_OUTSTANDING(MAXO)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .sb          (bus),
        .busy_mask   (busy_mask),
        .hilo_busy   (hilo_busy),
        .outstanding (outstanding),
        .wb_error    (wb_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       v, nop, hr, hw, fl;
        bit [4:0] r1, r2, w;
        bit [1:0] wv, wh;
        bit [4:0] wr[2];
    } stim_t;

    typedef struct {
        logic        ready;
        logic [31:0] mask;
        logic        hilo;
        logic [5:0]  cnt;
        logic        err;
    } exp_t;

    exp_t expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: one pending flag per target (index 32 = HI/LO).
    bit mb[33];
    bit merr;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int mcount();
        int c = 0;
        for (int i = 0; i < 33; i++) c += mb[i];
        return c;
    endfunction

    function automatic bit model_ready(input stim_t s);
        bit raw, waw, full;
        if (s.fl) return 1'b0;
        if (s.nop) return 1'b1;
        raw  = (s.r1 != 0 && mb[s.r1]) || (s.r2 != 0 && mb[s.r2]) || (s.hr && mb[32]);
        waw  = (s.w != 0 && mb[s.w]) || (s.hw && mb[32]);
        full = (s.w != 0 || s.hw) && mcount() == MAXO;
        return !(raw || waw || full);
    endfunction

    task automatic model_step(input stim_t s, input bit rdy);
        bit rel[33];
        bit nb[33];
        int tl[$];
        foreach (rel[i]) rel[i] = 1'b0;
        nb = mb;
        for (int k = 0; k < NWB; k++) begin
            if (s.wv[k]) begin
                tl.delete();
                if (s.wr[k] != 0) tl.push_back(int'(s.wr[k]));
                if (s.wh[k]) tl.push_back(32);
                foreach (tl[j]) begin
                    if (!mb[tl[j]] || rel[tl[j]]) merr = 1'b1;
                    rel[tl[j]] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 33; i++) if (rel[i]) nb[i] = 1'b0;
        if (s.v && rdy && !s.nop) begin
            if (s.w != 0) nb[s.w] = 1'b1;
            if (s.hw) nb[32] = 1'b1;
        end
        if (s.fl) foreach (nb[i]) nb[i] = 1'b0;
        mb = nb;
    endtask

    task automatic apply(input stim_t s);
        bus.issue_valid      = s.v;
        bus.issue_nop        = s.nop;
        bus.issue_read_1     = s.r1;
        bus.issue_read_2     = s.r2;
        bus.issue_write      = s.w;
        bus.issue_hilo_read  = s.hr;
        bus.issue_hilo_write = s.hw;
        bus.wb_valid         = s.wv;
        bus.wb_hilo          = s.wh;
        bus.wb_reg           = {s.wr[1], s.wr[0]};
        flush                = s.fl;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    // One cycle of stimulus: expectation reflects state after the previous edge.
    task automatic drive(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        apply(s);
        e.ready = model_ready(s);
        for (int i = 0; i < 32; i++) e.mask[i] = mb[i];
        e.hilo = mb[32];
        e.cnt  = 6'(mcount());
        e.err  = merr;
        expq.push_back(e);
        model_step(s, e.ready);
    endtask

    task automatic issue_w(input bit [4:0] w);
        stim_t s = idle();
        s.v = 1'b1;
        s.w = w;
        drive(s);
    endtask

    task automatic wb1(input bit [4:0] r);
        stim_t s = idle();
        s.wv    = 2'b01;
        s.wr[0] = r;
        drive(s);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #1;
        apply(idle());
        rst = 1'b1;
        #1;
        cmp("rst_busy_mask", busy_mask, 32'h0);
        cmp("rst_hilo_busy", {31'b0, hilo_busy}, 32'h0);
        cmp("rst_outstanding", {26'b0, outstanding}, 32'h0);
        cmp("rst_wb_error", {31'b0, wb_error}, 32'h0);
        #1;
        rst = 1'b0;
        foreach (mb[i]) mb[i] = 1'b0;
        merr = 1'b0;
    endtask

    // Monitor: every cycle the DUT presents outputs, check them against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && expq.size() > 0) begin
            e = expq.pop_front();
            cmp("issue_ready", {31'b0, bus.issue_ready}, {31'b0, e.ready});
            cmp("busy_mask", busy_mask, e.mask);
            cmp("hilo_busy", {31'b0, hilo_busy}, {31'b0, e.hilo});
            cmp("outstanding", {26'b0, outstanding}, {26'b0, e.cnt});
            cmp("wb_error", {31'b0, wb_error}, {31'b0, e.err});
        end
    end

    initial begin
        stim_t s;
        int    busy_list[$];
        int    guard;
        foreach (mb[i]) mb[i] = 1'b0;
        merr  = 1'b0;
        rst   = 1'b1;
        apply(idle());
        #12;
        rst = 1'b0;
        #1;
        cmp("init_busy_mask", busy_mask, 32'h0);
        cmp("init_outstanding", {26'b0, outstanding}, 32'h0);
        cmp("init_wb_error", {31'b0, wb_error}, 32'h0);

        // RAW on r5 and release timing.
        issue_w(5);
        s = idle(); s.v = 1; s.r1 = 5;
        drive(s);
        #1;
        cmp("raw_r5_blocked", {31'b0, bus.issue_ready}, 32'h0);
        cmp("busy_r5_mask", busy_mask, 32'h20);
        cmp("busy_r5_count", {26'b0, outstanding}, 32'h1);
        s.wv = 2'b01; s.wr[0] = 5;
        drive(s);
        s = idle(); s.v = 1; s.r1 = 5;
        drive(s);
        #1;
        cmp("raw_r5_released", {31'b0, bus.issue_ready}, 32'h1);

        // WAW on r7, nop with r0 destination.
        issue_w(7);
        issue_w(7);
        #1;
        cmp("waw_r7_blocked", {31'b0, bus.issue_ready}, 32'h0);
        s = idle(); s.v = 1; s.nop = 1;
        drive(s);
        drive(idle());
        #1;
        cmp("nop_mask_same", busy_mask, 32'h80);
        wb1(7);

        // MULT then MFLO.
        s = idle(); s.v = 1; s.hw = 1;
        drive(s);
        s = idle(); s.v = 1; s.hr = 1;
        drive(s);
        #1;
        cmp("mflo_blocked", {31'b0, bus.issue_ready}, 32'h0);
        s.wv = 2'b10; s.wh = 2'b10;
        drive(s);
        s = idle(); s.v = 1; s.hr = 1;
        drive(s);
        #1;
        cmp("mflo_accepted", {31'b0, bus.issue_ready}, 32'h1);
        cmp("hilo_released", {31'b0, hilo_busy}, 32'h0);

        // Fill to MAX_OUTSTANDING.
        for (int r = 1; r <= 8; r++) issue_w(5'(r));
        issue_w(9);
        #1;
        cmp("full_blocks_write", {31'b0, bus.issue_ready}, 32'h0);
        s = idle(); s.v = 1; s.r1 = 9;
        drive(s);
        #1;
        cmp("full_allows_read", {31'b0, bus.issue_ready}, 32'h1);
        s = idle(); s.v = 1; s.w = 9; s.wv = 2'b01; s.wr[0] = 1;
        drive(s);
        issue_w(9);
        #1;
        cmp("full_relieved", {31'b0, bus.issue_ready}, 32'h1);
        for (int r = 2; r <= 9; r += 2) begin
            s = idle(); s.wv = 2'b11; s.wr[0] = 5'(r); s.wr[1] = 5'(r + 1);
            drive(s);
        end

        // Duplicate release and release of an idle register.
        issue_w(3);
        s = idle(); s.wv = 2'b11; s.wr[0] = 3; s.wr[1] = 3;
        drive(s);
        wb1(12);
        drive(idle());
        drive(idle());
        #1;
        cmp("wb_error_sticky", {31'b0, wb_error}, 32'h1);

        // Flush with a valid issue.
        issue_w(1);
        issue_w(2);
        s = idle(); s.v = 1; s.hw = 1;
        drive(s);
        s = idle(); s.v = 1; s.w = 4; s.fl = 1;
        drive(s);
        #1;
        cmp("flush_blocks", {31'b0, bus.issue_ready}, 32'h0);
        drive(idle());
        #1;
        cmp("flush_mask", busy_mask, 32'h0);
        cmp("flush_count", {26'b0, outstanding}, 32'h0);
        cmp("flush_keeps_err", {31'b0, wb_error}, 32'h1);

        // Asynchronous reset mid-operation.
        issue_w(6);
        s = idle(); s.v = 1; s.hw = 1;
        drive(s);
        reset_pulse();

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            s = idle();
            s.v   = ($urandom_range(0, 9) < 8);
            s.nop = ($urandom_range(0, 9) == 0);
            s.r1  = 5'($urandom_range(0, 12));
            s.r2  = 5'($urandom_range(0, 12));
            s.w   = 5'($urandom_range(0, 12));
            s.hw  = ($urandom_range(0, 99) < 15);
            s.hr  = ($urandom_range(0, 99) < 15);
            s.fl  = ($urandom_range(0, 99) < 2);
            busy_list.delete();
            for (int i = 1; i < 32; i++) if (mb[i]) busy_list.push_back(i);
            for (int k = 0; k < NWB; k++) begin
                if ($urandom_range(0, 9) < 4) begin
                    s.wv[k] = 1'b1;
                    if (busy_list.size() > 0 && $urandom_range(0, 19) != 0)
                        s.wr[k] = 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
                    else
                        s.wr[k] = 5'($urandom_range(0, 12));
                    s.wh[k] = mb[32] && ($urandom_range(0, 9) < 3);
                end
            end
            drive(s);
            if (c == 1000) reset_pulse();
        end
        apply(idle());

        guard = 0;
        while (expq.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (expq.size() > 0) cmp("drain_timeout", 32'(expq.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
